// File: rtl/keypad_encoder_4x4_pkg.sv
// ---------------------------------------------------------------------------
// ula_pkg
// Shared definitions for the keypad input end of the ULA datapath.
//   kp_state_e        : scanner FSM states (SCAN, CONFIRM, HELD)
//   kp_code_t         : 4-bit key code, 4*row + col
//   col_enc_t         : result of the column priority encoder
//   col_priority_enc  : lowest-index low column wins; hit when any column is low
// ---------------------------------------------------------------------------
package ula_pkg;

    localparam int KP_ROWS = 4;
    localparam int KP_COLS = 4;
    localparam logic [KP_COLS-1:0] NO_COL = 4'b1111;

    typedef enum logic [1:0] {
        SCAN,
        CONFIRM,
        HELD
    } kp_state_e;

    typedef logic [3:0] kp_code_t;

    typedef struct packed {
        logic       hit;
        logic [1:0] col;
    } col_enc_t;

    // Columns are active-low; column 0 has the highest priority.
    function automatic col_enc_t col_priority_enc(input logic [KP_COLS-1:0] cols);
        col_enc_t res;
        res.hit = (cols != NO_COL);
        res.col = 2'd0;
        for (int i = KP_COLS - 1; i >= 0; i--) begin
            if (!cols[i]) begin
                res.col = 2'(i);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/keypad_encoder_4x4_if.sv
// ---------------------------------------------------------------------------
// keypad_encoder_4x4_if
// Key-code handover between the keypad encoder and its consumer.
//   key_code  : encoded key (4*row + col)
//   key_valid : key_code holds an undelivered code
//   key_ready : consumer accepts when key_valid && key_ready
//   pressed   : an accepted key is still held down
//   overrun   : one-cycle pulse when a code was dropped (buffer full)
// master = encoder side, slave = consumer side.
// ---------------------------------------------------------------------------
interface keypad_encoder_4x4_if;
    import ula_pkg::*;

    kp_code_t key_code;
    logic     key_valid;
    logic     key_ready;
    logic     pressed;
    logic     overrun;

    modport master (
        output key_code,
        output key_valid,
        output pressed,
        output overrun,
        input  key_ready
    );

    modport slave (
        input  key_code,
        input  key_valid,
        input  pressed,
        input  overrun,
        output key_ready
    );

endinterface

// File: rtl/keypad_encoder_4x4_sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for the asynchronous keypad column lines.
//   clk      : destination clock
//   rst      : synchronous active-high reset, flops load all ones (idle level)
//   async_in : asynchronous input bus
//   sync_out : synchronized copy, two clocks of latency
// ---------------------------------------------------------------------------
module sync_2ff #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out
);

    logic [WIDTH-1:0] meta_reg;
    logic [WIDTH-1:0] sync_reg;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            always_ff @(posedge clk) begin
                if (rst) begin
                    meta_reg[gi] <= 1'b1;
                    sync_reg[gi] <= 1'b1;
                end else begin
                    meta_reg[gi] <= async_in[gi];
                    sync_reg[gi] <= meta_reg[gi];
                end
            end
        end
    endgenerate

    assign sync_out = sync_reg;

endmodule

// File: rtl/keypad_encoder_4x4.sv
// ---------------------------------------------------------------------------
// keypad_encoder_4x4
// Scans a 4x4 matrix keypad, debounces presses and releases, and hands each
// accepted key code (4*row + col) to the consumer on a valid/ready link.
//   clk     : system clock, rising edge
//   rst     : synchronous active-high reset
//   row_out : row drive, active-low one-hot
//   col_in  : column sense, active-low, asynchronous
//   kp      : key_code/key_valid/key_ready/pressed/overrun (master side)
// Parameters: SCAN_DIV cycles per row (>=4), DEBOUNCE samples to accept a
// press or release (>=1), CNT_W row-timer width (2^CNT_W >= SCAN_DIV).
// ---------------------------------------------------------------------------
module keypad_encoder_4x4
    import ula_pkg::*;
#(
    parameter int SCAN_DIV = 4,
    parameter int DEBOUNCE = 3,
    parameter int CNT_W    = 8
) (
    input  logic                clk,
    input  logic                rst,
    output logic [KP_ROWS-1:0]  row_out,
    input  logic [KP_COLS-1:0]  col_in,
    keypad_encoder_4x4_if.master kp
);

    localparam int DB_W = $clog2(DEBOUNCE + 1);
    localparam logic [CNT_W-1:0] TIMER_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE - 1);
    localparam logic [KP_ROWS-1:0] ROW0_DRIVE = {{(KP_ROWS-1){1'b1}}, 1'b0};

    logic [KP_COLS-1:0] col_s;
    col_enc_t           enc;
    logic               sample;
    kp_code_t           hit_code;
    logic               emit;
    kp_code_t           emit_code;

    kp_state_e          state_reg;
    logic [CNT_W-1:0]   timer_reg;
    logic [1:0]         row_idx_reg;
    logic [KP_ROWS-1:0] row_out_reg;
    kp_code_t           cand_reg;
    logic [DB_W-1:0]    match_cnt_reg;
    logic [DB_W-1:0]    rel_cnt_reg;
    kp_code_t           key_code_reg;
    logic               key_valid_reg;
    logic               pressed_reg;
    logic               overrun_reg;

    sync_2ff #(
        .WIDTH (KP_COLS)
    ) u_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (col_in),
        .sync_out (col_s)
    );

    assign enc      = col_priority_enc(col_s);
    assign sample   = (timer_reg == TIMER_LAST);
    assign hit_code = {row_idx_reg, enc.col};

    // A code is emitted on the sample that completes the press debounce.
    // With DEBOUNCE==1 the first hit in SCAN already qualifies.
    always_comb begin
        emit      = 1'b0;
        emit_code = cand_reg;
        if (sample) begin
            if (state_reg == SCAN && enc.hit && DEBOUNCE == 1) begin
                emit      = 1'b1;
                emit_code = hit_code;
            end
            if (state_reg == CONFIRM && enc.hit && hit_code == cand_reg
                && match_cnt_reg == DB_LAST) begin
                emit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= SCAN;
            timer_reg     <= '0;
            row_idx_reg   <= 2'd0;
            row_out_reg   <= ROW0_DRIVE;
            cand_reg      <= '0;
            match_cnt_reg <= '0;
            rel_cnt_reg   <= '0;
            key_code_reg  <= '0;
            key_valid_reg <= 1'b0;
            pressed_reg   <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            timer_reg   <= sample ? '0 : timer_reg + CNT_W'(1);
            overrun_reg <= 1'b0;

            // Output buffer: a load may coincide with an accept; a load onto
            // an unaccepted code is dropped and flagged instead.
            if (emit) begin
                if (!key_valid_reg || kp.key_ready) begin
                    key_code_reg  <= emit_code;
                    key_valid_reg <= 1'b1;
                end else begin
                    overrun_reg <= 1'b1;
                end
            end else if (key_valid_reg && kp.key_ready) begin
                key_valid_reg <= 1'b0;
            end

            if (sample) begin
                case (state_reg)
                    SCAN: begin
                        if (enc.hit) begin
                            cand_reg <= hit_code;
                            if (DEBOUNCE == 1) begin
                                state_reg   <= HELD;
                                pressed_reg <= 1'b1;
                                rel_cnt_reg <= '0;
                            end else begin
                                match_cnt_reg <= DB_W'(1);
                                state_reg     <= CONFIRM;
                            end
                        end else begin
                            row_idx_reg <= row_idx_reg + 2'd1;
                            row_out_reg <= {row_out_reg[KP_ROWS-2:0], row_out_reg[KP_ROWS-1]};
                        end
                    end
                    CONFIRM: begin
                        if (enc.hit && hit_code == cand_reg) begin
                            if (match_cnt_reg == DB_LAST) begin
                                state_reg   <= HELD;
                                pressed_reg <= 1'b1;
                                rel_cnt_reg <= '0;
                            end else begin
                                match_cnt_reg <= match_cnt_reg + DB_W'(1);
                            end
                        end else begin
                            state_reg   <= SCAN;
                            row_idx_reg <= row_idx_reg + 2'd1;
                            row_out_reg <= {row_out_reg[KP_ROWS-2:0], row_out_reg[KP_ROWS-1]};
                        end
                    end
                    HELD: begin
                        // Any hit on the held row (even another key) keeps
                        // the press alive; only empty samples count.
                        if (enc.hit) begin
                            rel_cnt_reg <= '0;
                        end else if (rel_cnt_reg == DB_LAST) begin
                            pressed_reg <= 1'b0;
                            state_reg   <= SCAN;
                            row_idx_reg <= row_idx_reg + 2'd1;
                            row_out_reg <= {row_out_reg[KP_ROWS-2:0], row_out_reg[KP_ROWS-1]};
                        end else begin
                            rel_cnt_reg <= rel_cnt_reg + DB_W'(1);
                        end
                    end
                    default: begin
                        state_reg <= SCAN;
                    end
                endcase
            end
        end
    end

    assign row_out      = row_out_reg;
    assign kp.key_code  = key_code_reg;
    assign kp.key_valid = key_valid_reg;
    assign kp.pressed   = pressed_reg;
    assign kp.overrun   = overrun_reg;

endmodule

// File: tb/tb_keypad_encoder_4x4.sv
// ---------------------------------------------------------------------------
// tb_keypad_encoder_4x4
// Keypad model: a pressed key shorts its row line to its column line, so a
// column reads low only while that key's row is driven. The stimulus process
// pushes the code each press should yield (4*row + lowest pressed column);
// the monitor pops and compares on every handshake.
// ---------------------------------------------------------------------------
module tb_keypad_encoder_4x4;
    import ula_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  row_out;
    logic [3:0]  col_in;
    logic [15:0] keys;

    keypad_encoder_4x4_if kp_if ();

    keypad_encoder_4x4 #(
        .SCAN_DIV (4),
        .DEBOUNCE (3),
        .CNT_W    (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .row_out (row_out),
        .col_in  (col_in),
        .kp      (kp_if.master)
    );

    always #5 clk = ~clk;

    always_comb begin
        col_in = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!row_out[r] && keys[r*4 + c]) begin
                    col_in[c] = 1'b0;
                end
            end
        end
    end

    int checks      = 0;
    int errors      = 0;
    int exp_q[$];
    int pushes      = 0;
    int handshakes  = 0;
    int overrun_seen = 0;
    int exp_overrun = 0;
    bit rand_ready  = 1'b0;

    task automatic check(input string name, input int actual, input int required);
        checks++;
        if (actual != required) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, actual, required);
        end
    endtask

    task automatic expect_code(input int code);
        exp_q.push_back(code);
        pushes++;
    endtask

    task automatic tick();
        @(negedge clk);
        if (rand_ready) kp_if.key_ready = 1'($urandom_range(1));
    endtask

    task automatic wait_pressed(input logic v, input int limit, output int n);
        n = 0;
        while (kp_if.pressed !== v && n < limit) begin
            tick();
            n++;
        end
        if (kp_if.pressed !== v) begin
            checks++;
            errors++;
            $display("FAIL wait_pressed actual=%0b required=%0b after %0d cycles", kp_if.pressed, v, n);
        end
    endtask

    task automatic wait_row(input logic [3:0] v, input int limit);
        int n = 0;
        while (row_out !== v && n < limit) begin
            tick();
            n++;
        end
        if (row_out !== v) begin
            checks++;
            errors++;
            $display("FAIL wait_row actual=%b required=%b", row_out, v);
        end
    endtask

    // Monitor / scoreboard
    initial begin
        logic       prev_hold;
        logic [3:0] prev_code;
        prev_hold = 1'b0;
        prev_code = 4'h0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                prev_hold = 1'b0;
            end else begin
                if (prev_hold) begin
                    check("valid_held", int'(kp_if.key_valid), 1);
                    check("code_stable", int'(kp_if.key_code), int'(prev_code));
                end
                if (kp_if.key_valid && kp_if.key_ready) begin
                    handshakes++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_code actual=%0h required=none", kp_if.key_code);
                    end else begin
                        check("key_code", int'(kp_if.key_code), exp_q.pop_front());
                    end
                end
                if (kp_if.overrun) overrun_seen++;
                prev_hold = kp_if.key_valid && !kp_if.key_ready;
                prev_code = kp_if.key_code;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] one;
        logic [3:0] exp_row;
        int n;
        int early;
        one = 4'b0001;

        // 1: reset, then idle scan
        rst = 1'b1;
        keys = '0;
        kp_if.key_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        check("rst_row_out", int'(row_out), 'hE);
        check("rst_key_valid", int'(kp_if.key_valid), 0);
        check("rst_pressed", int'(kp_if.pressed), 0);
        check("rst_overrun", int'(kp_if.overrun), 0);
        check("rst_key_code", int'(kp_if.key_code), 0);
        for (int k = 0; k < 64; k++) begin
            if (k > 0) tick();
            exp_row = 4'hF ^ (one << ((k / 4) % 4));
            check("idle_row", int'(row_out), int'(exp_row));
            if (k % 16 == 15) begin
                check("idle_valid", int'(kp_if.key_valid), 0);
                check("idle_pressed", int'(kp_if.pressed), 0);
            end
        end

        // 2: row 2 col 1 held, one code 9
        kp_if.key_ready = 1'b1;
        keys[9] = 1'b1;
        expect_code(9);
        repeat (40) tick();
        check("t2_pressed", int'(kp_if.pressed), 1);
        keys = '0;
        wait_pressed(1'b0, 40, n);
        checks++;
        if (n < 11 || n > 14) begin
            errors++;
            $display("FAIL t2_release_delay actual=%0d required=11..14", n);
        end
        check("t2_scan_resumes", int'(row_out), 'h7);

        // 3: single-sample bounce on row 0 col 3
        wait_row(4'b0111, 20);
        wait_row(4'b1110, 20);
        keys[3] = 1'b1;
        repeat (3) tick();
        keys = '0;
        tick();
        check("t3_row_held", int'(row_out), 'hE);
        repeat (4) tick();
        check("t3_row_advance", int'(row_out), 'hD);
        check("t3_valid", int'(kp_if.key_valid), 0);
        check("t3_pressed", int'(kp_if.pressed), 0);
        check("t3_overrun_count", overrun_seen, 0);

        // 4: row 1 cols 0 and 3, col 0 wins
        keys[4] = 1'b1;
        keys[7] = 1'b1;
        expect_code(4);
        repeat (40) tick();
        check("t4_pressed", int'(kp_if.pressed), 1);
        keys = '0;
        wait_pressed(1'b0, 40, n);

        // 5: consumer stalled, second code overruns
        kp_if.key_ready = 1'b0;
        keys[14] = 1'b1;
        expect_code(14);
        wait_pressed(1'b1, 60, n);
        keys = '0;
        wait_pressed(1'b0, 40, n);
        keys[0] = 1'b1;
        wait_pressed(1'b1, 60, n);
        exp_overrun++;
        check("t5_overrun_pulse", int'(kp_if.overrun), 1);
        check("t5_valid", int'(kp_if.key_valid), 1);
        check("t5_code_kept", int'(kp_if.key_code), 'hE);
        tick();
        check("t5_overrun_one_cycle", int'(kp_if.overrun), 0);
        keys = '0;
        wait_pressed(1'b0, 40, n);
        check("t5_code_still", int'(kp_if.key_code), 'hE);
        kp_if.key_ready = 1'b1;
        tick();
        check("t5_valid_drop", int'(kp_if.key_valid), 0);

        // 6: reset while HELD on 5 with an undelivered code
        kp_if.key_ready = 1'b0;
        keys[5] = 1'b1;
        wait_pressed(1'b1, 60, n);
        check("t6_valid_before", int'(kp_if.key_valid), 1);
        check("t6_code_before", int'(kp_if.key_code), 5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_valid_after_rst", int'(kp_if.key_valid), 0);
        check("t6_pressed_after_rst", int'(kp_if.pressed), 0);
        check("t6_row_after_rst", int'(row_out), 'hE);
        check("t6_code_after_rst", int'(kp_if.key_code), 0);
        early = 0;
        for (int k = 1; k < 16; k++) begin
            tick();
            if (kp_if.key_valid) early++;
        end
        check("t6_no_early_valid", early, 0);
        tick();
        check("t6_reemit_valid", int'(kp_if.key_valid), 1);
        check("t6_reemit_code", int'(kp_if.key_code), 5);
        expect_code(5);
        kp_if.key_ready = 1'b1;
        tick();
        check("t6_valid_drop", int'(kp_if.key_valid), 0);
        keys = '0;
        wait_pressed(1'b0, 40, n);

        // Random presses (one row, one or two columns) with random ready
        rand_ready = 1'b1;
        for (int it = 0; it < 12; it++) begin
            int r;
            int c1;
            int c2;
            int exp_col;
            n = 0;
            while (kp_if.key_valid && n < 200) begin
                tick();
                n++;
            end
            r  = int'($urandom_range(3));
            c1 = int'($urandom_range(3));
            exp_col = c1;
            keys[r*4 + c1] = 1'b1;
            if ($urandom_range(1) == 1) begin
                c2 = int'($urandom_range(3));
                keys[r*4 + c2] = 1'b1;
                if (c2 < exp_col) exp_col = c2;
            end
            expect_code(4*r + exp_col);
            repeat ($urandom_range(40, 70)) tick();
            check("rnd_pressed", int'(kp_if.pressed), 1);
            keys = '0;
            wait_pressed(1'b0, 40, n);
            repeat ($urandom_range(2, 12)) tick();
        end
        rand_ready = 1'b0;
        kp_if.key_ready = 1'b1;
        repeat (5) tick();

        check("queue_drained", exp_q.size(), 0);
        check("handshake_count", handshakes, pushes);
        check("overrun_count", overrun_seen, exp_overrun);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/keypad_encoder_4x4.md
Name: keypad_encoder_4x4

Overview:
- Scans a 4x4 matrix keypad and encodes each debounced key press into a 4-bit code.
- Hands each code over on a valid/ready interface to the ULA operand/opcode input path.
- This is the input end of the datapath whose 4-bit values the display decoders render on the 7-segment outputs.
- One clock domain. The column inputs are asynchronous and are synchronized inside the block.

Parameters:
- SCAN_DIV, 4: clock cycles each row is driven before its columns are sampled. Minimum 4.
- DEBOUNCE, 3: consecutive matching samples required to accept a press, and consecutive empty samples required to accept a release. Minimum 1.
- CNT_W, 8: width of the row-period timer. Must satisfy 2^CNT_W >= SCAN_DIV.

Ports:
- clk, in, 1: system clock. All flops are rising-edge.
- rst, in, 1: synchronous, active-high reset.
- row_out, out, 4: row drive, active-low, one-hot-low. Bit r low means row r is driven.
- col_in, in, 4: column sense, active-low, externally pulled up, asynchronous.
- key_code, out, 4: encoded key, equal to 4*row + col.
- key_valid, out, 1: key_code holds an undelivered code.
- key_ready, in, 1: consumer accepts the code on a cycle where key_valid and key_ready are both high.
- pressed, out, 1: high while an accepted key is still held down.
- overrun, out, 1: one-cycle pulse when a new code is dropped because the output buffer is full.

Behaviour:
- Reset: one clock, one reset. Reset is synchronous and active-high. On a cycle with rst=1, all state loads its reset value on that edge:
  - row_out=4'b1110, row_idx=0, timer=0, FSM=SCAN
  - key_valid=0, key_code=4'h0, pressed=0, overrun=0
  - synchronizer flops=4'b1111
  - Reset mid-operation (CONFIRM or HELD) discards any candidate and emits nothing.
- Synchronizer: col_in passes through 2 flops to give col_s. Only col_s is used.
- Timer: counts 0..SCAN_DIV-1 and wraps. The "sample point" is the cycle where timer==SCAN_DIV-1. col_s is evaluated only at sample points.
- Column encode: the lowest-index low column wins (col 0 has the highest priority). hit = any col_s bit is 0.
- SCAN state:
  - At a sample point with no hit: row_idx increments mod 4 and row_out rotates.
  - At a sample point with a hit: cand = {row_idx, col_enc}, match count=1, go to CONFIRM. The row is not advanced.
  - If DEBOUNCE==1, go straight to emit and then HELD.
- CONFIRM state: the row is held.
  - At each sample point, if hit and the encoded code equals cand, the count increments.
  - When the count reaches DEBOUNCE: emit cand, go to HELD.
  - On a miss or a different code: return to SCAN and advance the row.
- HELD state: the row is held and pressed=1.
  - At each sample point with no hit, the release counter increments. Any hit clears it.
  - When the release counter reaches DEBOUNCE: pressed=0, go to SCAN, advance the row.
  - Other keys pressed meanwhile are ignored (no rollover).
- Emit and handshake:
  - An emit is a one-cycle event on the edge after the qualifying sample.
  - If key_valid=0, or key_valid=1 with key_ready=1 on the same cycle: key_code<=cand and key_valid<=1. Simultaneous accept and load keeps key_valid at 1 with the new code.
  - If key_valid=1 and key_ready=0: the new code is dropped and overrun pulses for 1 cycle. The old code is retained.
  - On accept with no emit, key_valid<=0 on the next edge.
  - key_code is stable while key_valid=1 and key_ready=0.
- Latency: key_valid rises 1 cycle after the DEBOUNCE-th matching sample point. A steady press is confirmed within (DEBOUNCE-1)*SCAN_DIV cycles of its first sample.
- Widths: row_idx is 2 bits, col_enc is 2 bits, both counters are ceil(log2(DEBOUNCE+1)) bits. All counters saturate and never wrap mid-state.

Decomposition:
- Shared package ula_pkg:
  - FSM state enum: SCAN, CONFIRM, HELD.
  - Constants KP_ROWS=4, KP_COLS=4, NO_COL=4'b1111.
  - The function col_priority_enc(4-bit) returning 2 bits plus a hit flag.
- One sub-module: sync_2ff (4-bit two-flop synchronizer, reset to 1s). Everything else lives inline.

Test Plan:
- The bench runs SCAN_DIV=4, DEBOUNCE=3.
1. Reset for 3 cycles, then idle 64 cycles with col_in=1111 -> row_out cycles 1110,1101,1011,0111 every 4 cycles; key_valid=0; pressed=0.
2. Hold row 2, col 1 (col_in=1101 only while row_out=1011) for 40 cycles with key_ready=1 -> exactly one key_valid pulse with key_code=4'h9. pressed is high until 3 empty samples after release, then scanning resumes.
3. Bounce: row 0, col 3 low for a single sample point only -> CONFIRM then back to SCAN; no key_valid; no overrun.
4. Row 1 with cols 0 and 3 both low (col_in=0110), steady -> key_code=4'h4 (col 0 has priority).
5. key_ready=0: press and release row 3 col 2, then row 0 col 0 -> key_code stays 4'hE with key_valid=1; overrun pulses once at the second emit. Raising key_ready then drops key_valid on the next cycle.
6. Assert rst for 1 cycle while in HELD on code 4'h5 with key_valid=1 -> next cycle key_valid=0, pressed=0, row_out=1110. With the key still held afterwards, the code is re-emitted only after a full 3-sample debounce.
